// File: rtl/volts_capture_buffer.sv
// Frame capture buffer: stores Depth ADC samples, then streams them out over valid/ready.
// Readout is one word per two cycles at best (address cycle, then registered-data cycle).
module volts_capture_buffer #(
  parameter int Width     = 12,
  parameter int Depth     = 310,
  parameter int AddrWidth = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 sample_valid_i,
  input  logic [Width-1:0]     sample_i,
  input  logic                 rd_start_i,
  output logic [Width-1:0]     dout_o,
  output logic                 dout_valid_o,
  input  logic                 dout_ready_i,
  output logic [AddrWidth:0]   count_o,
  output logic                 busy_o,
  output logic                 full_o,
  output logic                 done_o,
  output logic                 overrun_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_FULL    = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;

  localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(Depth - 1);
  localparam logic [AddrWidth:0]   FullCount = (AddrWidth + 1)'(Depth);

  logic [Width-1:0]     r_ram [Depth];
  logic [2:0]           r_state;
  logic [AddrWidth-1:0] r_wr_ptr;
  logic [AddrWidth-1:0] r_rd_ptr;
  logic [AddrWidth:0]   r_count;
  logic [Width-1:0]     r_dout;
  logic                 r_dout_valid;
  logic                 r_done;
  logic                 r_overrun;
  logic                 w_wr_en;

  // A restart in the same cycle as a strobe drops that sample.
  assign w_wr_en = (r_state == S_CAPTURE) && sample_valid_i && !start_i;

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_ram[r_wr_ptr] <= sample_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state   <= S_CAPTURE;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (start_i) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
          end else if (sample_valid_i) begin
            if (r_wr_ptr == LastAddr) begin
              r_state <= S_FULL;
              r_count <= FullCount;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              r_count  <= r_count + 1'b1;
            end
          end
        end
        S_FULL: begin
          if (start_i) begin
            r_state   <= S_CAPTURE;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
          end else begin
            if (rd_start_i) begin
              r_state  <= S_RD_ADDR;
              r_rd_ptr <= '0;
            end
            if (sample_valid_i) begin
              r_overrun <= 1'b1;
            end
          end
        end
        S_RD_ADDR: begin
          r_dout       <= r_ram[r_rd_ptr];
          r_dout_valid <= 1'b1;
          r_state      <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (dout_ready_i) begin
            r_dout_valid <= 1'b0;
            if (r_rd_ptr == LastAddr) begin
              r_state  <= S_FULL;
              r_done   <= 1'b1;
              r_rd_ptr <= '0;
            end else begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
              r_state  <= S_RD_ADDR;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dout_o       = r_dout;
  assign dout_valid_o = r_dout_valid;
  assign count_o      = r_count;
  assign busy_o       = (r_state == S_CAPTURE) || (r_state == S_RD_ADDR) || (r_state == S_RD_DATA);
  assign full_o       = (r_state == S_FULL);
  assign done_o       = r_done;
  assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_volts_capture_buffer.sv
// Directed bench for volts_capture_buffer at default parameters (12 x 310).
module tb_volts_capture_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        sample_valid_i;
  logic [11:0] sample_i;
  logic        rd_start_i;
  logic [11:0] dout_o;
  logic        dout_valid_o;
  logic        dout_ready_i;
  logic [9:0]  count_o;
  logic        busy_o;
  logic        full_o;
  logic        done_o;
  logic        overrun_o;

  int checks = 0;
  int passes = 0;

  logic [11:0] rd_words [$];
  int          r_ncyc;
  int          r_ndone;
  int          r_hold_bad;
  int          r_stalled;

  volts_capture_buffer dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .sample_valid_i (sample_valid_i),
    .sample_i       (sample_i),
    .rd_start_i     (rd_start_i),
    .dout_o         (dout_o),
    .dout_valid_o   (dout_valid_o),
    .dout_ready_i   (dout_ready_i),
    .count_o        (count_o),
    .busy_o         (busy_o),
    .full_o         (full_o),
    .done_o         (done_o),
    .overrun_o      (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic capture_frame(input logic [11:0] pat);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int n = 0; n < 310; n++) begin
      sample_valid_i = 1'b1;
      sample_i       = 12'(n) ^ pat;
      tick();
    end
    sample_valid_i = 1'b0;
  endtask

  // Stream one frame; holds ready low for stall_len observations on word stall_word.
  task automatic read_frame(input int stall_word, input int stall_len);
    logic [11:0] held;
    held       = '0;
    rd_words.delete();
    r_ncyc     = -1;
    r_ndone    = 0;
    r_hold_bad = 0;
    r_stalled  = 0;
    dout_ready_i = 1'b1;
    rd_start_i   = 1'b1;
    tick();
    rd_start_i = 1'b0;
    for (int c = 0; c < 2000 && r_ncyc < 0; c++) begin
      if (done_o) begin
        r_ndone++;
        r_ncyc = c;
      end else if (dout_valid_o) begin
        if (rd_words.size() == stall_word && r_stalled < stall_len) begin
          if (r_stalled > 0 && dout_o !== held) r_hold_bad++;
          held = dout_o;
          r_stalled++;
          dout_ready_i = 1'b0;
        end else begin
          if (r_stalled > 0 && rd_words.size() == stall_word && dout_o !== held) r_hold_bad++;
          dout_ready_i = 1'b1;
          rd_words.push_back(dout_o);
        end
      end else begin
        if (r_stalled > 0 && r_stalled <= stall_len && rd_words.size() == stall_word) r_hold_bad++;
        dout_ready_i = 1'b1;
      end
      if (r_ncyc < 0) tick();
    end
    tick();
    if (done_o) r_ndone++;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; start_i = 1'b0; sample_valid_i = 1'b0; sample_i = '0;
    rd_start_i = 1'b0; dout_ready_i = 1'b0;
    tick(); tick();
    checks++; if (dout_o !== 12'd0) $display("FAIL reset_dout got %0d want 0", dout_o); else passes++;
    checks++; if (dout_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", dout_valid_o); else passes++;
    checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else passes++;
    checks++; if (full_o !== 1'b0) $display("FAIL reset_full got %b want 0", full_o); else passes++;
    checks++; if (done_o !== 1'b0) $display("FAIL reset_done got %b want 0", done_o); else passes++;
    checks++; if (overrun_o !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun_o); else passes++;
    checks++; if (count_o !== 10'd0) $display("FAIL reset_count got %0d want 0", count_o); else passes++;
    rst_i = 1'b0;
    tick();
    rd_start_i = 1'b1;
    tick();
    rd_start_i = 1'b0;
    tick();
    checks++; if (busy_o !== 1'b0 || dout_valid_o !== 1'b0) $display("FAIL idle_rd_start busy=%b valid=%b want 0/0", busy_o, dout_valid_o); else passes++;
  endtask

  task automatic test_capture;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++; if (busy_o !== 1'b1 || count_o !== 10'd0) $display("FAIL cap_start busy=%b count=%0d want 1/0", busy_o, count_o); else passes++;
    for (int n = 0; n < 310; n++) begin
      sample_valid_i = 1'b1;
      sample_i       = 12'(n);
      tick();
      if (n == 99) begin
        checks++; if (count_o !== 10'd100) $display("FAIL cap_count100 got %0d want 100", count_o); else passes++;
      end
      if (n == 308) begin
        checks++; if (full_o !== 1'b0 || count_o !== 10'd309) $display("FAIL cap_309 full=%b count=%0d want 0/309", full_o, count_o); else passes++;
      end
    end
    sample_valid_i = 1'b0;
    checks++; if (full_o !== 1'b1) $display("FAIL cap_full got %b want 1", full_o); else passes++;
    checks++; if (count_o !== 10'd310) $display("FAIL cap_count got %0d want 310", count_o); else passes++;
    checks++; if (busy_o !== 1'b0) $display("FAIL cap_busy got %b want 0", busy_o); else passes++;
  endtask

  task automatic test_readout;
    int bad;
    read_frame(-1, 0);
    bad = 0;
    foreach (rd_words[i]) if (rd_words[i] !== 12'(i)) bad++;
    checks++; if (rd_words.size() != 310) $display("FAIL rd_words got %0d want 310", rd_words.size()); else passes++;
    checks++; if (bad != 0) $display("FAIL rd_order got %0d bad words want 0", bad); else passes++;
    checks++; if (r_ncyc != 620) $display("FAIL rd_cycles got %0d want 620", r_ncyc); else passes++;
    checks++; if (r_ndone != 1) $display("FAIL rd_done_pulses got %0d want 1", r_ndone); else passes++;
    checks++; if (full_o !== 1'b1 || busy_o !== 1'b0 || dout_valid_o !== 1'b0) $display("FAIL rd_end full=%b busy=%b valid=%b want 1/0/0", full_o, busy_o, dout_valid_o); else passes++;
  endtask

  task automatic test_stall;
    int bad;
    read_frame(7, 5);
    bad = 0;
    foreach (rd_words[i]) if (rd_words[i] !== 12'(i)) bad++;
    checks++; if (rd_words.size() != 310 || bad != 0) $display("FAIL stall_seq got size=%0d bad=%0d want 310/0", rd_words.size(), bad); else passes++;
    checks++; if (r_stalled != 5 || r_hold_bad != 0) $display("FAIL stall_hold got stalled=%0d unstable=%0d want 5/0", r_stalled, r_hold_bad); else passes++;
    checks++; if (r_ncyc != 625) $display("FAIL stall_cycles got %0d want 625", r_ncyc); else passes++;
    checks++; if (r_ndone != 1) $display("FAIL stall_done got %0d want 1", r_ndone); else passes++;
  endtask

  task automatic test_overrun;
    sample_valid_i = 1'b1;
    sample_i       = 12'hABC;
    tick();
    sample_valid_i = 1'b0;
    checks++; if (overrun_o !== 1'b1 || full_o !== 1'b1 || count_o !== 10'd310) $display("FAIL ovr_set ovr=%b full=%b count=%0d want 1/1/310", overrun_o, full_o, count_o); else passes++;
    tick(); tick();
    checks++; if (overrun_o !== 1'b1) $display("FAIL ovr_sticky got %b want 1", overrun_o); else passes++;
    read_frame(-1, 0);
    checks++; if (rd_words.size() != 310 || rd_words[0] !== 12'd0 || rd_words[309] !== 12'd309) $display("FAIL ovr_replay got size=%0d w0=%0d w309=%0d want 310/0/309", rd_words.size(), rd_words[0], rd_words[309]); else passes++;
    checks++; if (overrun_o !== 1'b1) $display("FAIL ovr_after_replay got %b want 1", overrun_o); else passes++;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++; if (overrun_o !== 1'b0 || busy_o !== 1'b1 || count_o !== 10'd0) $display("FAIL ovr_clear ovr=%b busy=%b count=%0d want 0/1/0", overrun_o, busy_o, count_o); else passes++;
  endtask

  task automatic test_restart;
    for (int n = 0; n < 3; n++) begin
      sample_valid_i = 1'b1;
      sample_i       = 12'h123;
      tick();
    end
    checks++; if (count_o !== 10'd3) $display("FAIL rst_cap_count got %0d want 3", count_o); else passes++;
    start_i = 1'b1;
    sample_i = 12'h777;
    tick();
    start_i = 1'b0;
    sample_valid_i = 1'b0;
    checks++; if (count_o !== 10'd0 || busy_o !== 1'b1) $display("FAIL restart count=%0d busy=%b want 0/1", count_o, busy_o); else passes++;
    for (int n = 0; n < 310; n++) begin
      sample_valid_i = 1'b1;
      sample_i       = 12'(n) ^ 12'h5A5;
      tick();
    end
    sample_valid_i = 1'b0;
    read_frame(-1, 0);
    checks++; if (rd_words.size() != 310 || rd_words[0] !== 12'h5A5 || rd_words[200] !== (12'd200 ^ 12'h5A5)) $display("FAIL restart_data got size=%0d w0=%h w200=%h want 310/5a5/%h", rd_words.size(), rd_words[0], rd_words[200], 12'd200 ^ 12'h5A5); else passes++;
  endtask

  task automatic test_start_wins;
    int vld;
    start_i    = 1'b1;
    rd_start_i = 1'b1;
    tick();
    start_i    = 1'b0;
    rd_start_i = 1'b0;
    checks++; if (busy_o !== 1'b1 || full_o !== 1'b0 || count_o !== 10'd0) $display("FAIL both_start busy=%b full=%b count=%0d want 1/0/0", busy_o, full_o, count_o); else passes++;
    vld = 0;
    for (int c = 0; c < 4; c++) begin
      if (dout_valid_o) vld++;
      tick();
    end
    checks++; if (vld != 0) $display("FAIL both_no_valid got %0d valid cycles want 0", vld); else passes++;
  endtask

  task automatic test_reset_mid_read;
    int found;
    int ndone;
    capture_frame(12'h000);
    dout_ready_i = 1'b1;
    rd_start_i   = 1'b1;
    tick();
    rd_start_i = 1'b0;
    found = 0;
    for (int c = 0; c < 1000 && found == 0; c++) begin
      if (dout_valid_o && dout_o === 12'd100) found = 1;
      else tick();
    end
    checks++; if (found != 1) $display("FAIL midrd_word100 got found=%0d want 1", found); else passes++;
    rst_i = 1'b1;
    #1;
    checks++; if (dout_valid_o !== 1'b0 || full_o !== 1'b0 || busy_o !== 1'b0 || count_o !== 10'd0) $display("FAIL midrd_reset valid=%b full=%b busy=%b count=%0d want 0/0/0/0", dout_valid_o, full_o, busy_o, count_o); else passes++;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) rst_i = 1'b0;
      if (done_o) ndone++;
      tick();
    end
    if (done_o) ndone++;
    checks++; if (ndone != 0 || busy_o !== 1'b0 || full_o !== 1'b0) $display("FAIL midrd_after done=%0d busy=%b full=%b want 0/0/0", ndone, busy_o, full_o); else passes++;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_readout();
    test_stall();
    test_overrun();
    test_restart();
    test_start_wins();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
